// File: rtl/omsp_spm_cmd_seq_pkg.sv
// Shared definitions for the SPM command sequencer.
// FSM states, r15 status codes and key geometry.
package omsp_spm_cmd_seq_pkg;

  localparam int KEY_WORDS   = 8;
  localparam int KEY_TIMEOUT = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UPDATE,
    S_CHECK,
    S_KD_REQ,
    S_KEY,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [15:0] SPM_ST_OK      = 16'h0000;
  localparam logic [15:0] SPM_ST_VIOL    = 16'h0001;
  localparam logic [15:0] SPM_ST_TIMEOUT = 16'h0002;
  localparam logic [15:0] SPM_ST_COLL    = 16'h0003;

endpackage

// File: rtl/omsp_spm_cmd_seq_if.sv
// Key-derivation handshake between the key source
// (master) and the SPM command sequencer (slave).
interface omsp_spm_cmd_seq_if;

  logic [15:0] kd_word;
  logic        kd_valid;
  logic        kd_ready;
  logic        kd_start;

  modport master (
    output kd_word,
    output kd_valid,
    input  kd_ready,
    input  kd_start
  );

  modport slave (
    input  kd_word,
    input  kd_valid,
    output kd_ready,
    output kd_start
  );

endinterface

// File: rtl/omsp_spm_cmd_seq_key_stream.sv
// Key word streaming: word counter, stall timeout and
// zero-latency pass-through of accepted key words.
module omsp_spm_cmd_seq_key_stream
  import omsp_spm_cmd_seq_pkg::*;
#(
  parameter int KW  = KEY_WORDS,
  parameter int KTO = KEY_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        active_i,
  input  logic        clear_i,
  input  logic [15:0] kd_word_i,
  input  logic        kd_valid_i,
  output logic        kd_ready_o,
  output logic        write_key_o,
  output logic [15:0] key_in_o,
  output logic        done_o,
  output logic        timeout_o
);

  localparam int WW = (KW > 1) ? $clog2(KW) : 1;

  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [7:0]    to_q, to_d;
  logic          acc;

  always_comb begin
    acc         = active_i & kd_valid_i;
    kd_ready_o  = active_i;
    write_key_o = acc;
    key_in_o    = acc ? kd_word_i : 16'h0000;
    done_o      = acc && (wcnt_q == WW'(KW - 1));
    // Fires on the stalled cycle that brings the count to KTO.
    timeout_o   = active_i && !kd_valid_i
                  && (to_q == 8'(KTO - 1));
  end

  always_comb begin
    wcnt_d = wcnt_q;
    to_d   = to_q;
    if (clear_i) begin
      wcnt_d = '0;
      to_d   = '0;
    end else if (acc) begin
      wcnt_d = wcnt_q + 1'b1;
      to_d   = '0;
    end else if (active_i) begin
      if (to_q != 8'hFF) to_d = to_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q <= '0;
      to_q   <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      to_q   <= to_d;
    end
  end

endmodule

// File: rtl/omsp_spm_cmd_seq.sv
// SPM command sequencer: issues protect/unprotect updates,
// checks for violations and streams the module key.
module omsp_spm_cmd_seq
  import omsp_spm_cmd_seq_pkg::*;
#(
  parameter int KW  = KEY_WORDS,
  parameter int KTO = KEY_TIMEOUT
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                cmd_protect,
  input  logic                cmd_unprotect,
  input  logic                ctl_violation,
  omsp_spm_cmd_seq_if.slave   kd,
  output logic                update_spm,
  output logic                enable_spm,
  output logic                write_key,
  output logic [15:0]         key_in,
  output logic                spm_busy,
  output logic                cmd_done,
  output logic [15:0]         status
);

  state_e      state_q, state_d;
  logic [15:0] status_q, status_d;
  logic        enable_q, enable_d;
  logic        ks_active;
  logic        ks_clear;
  logic        ks_done;
  logic        ks_timeout;
  logic        kd_start_c;

  omsp_spm_cmd_seq_key_stream #(
    .KW  (KW),
    .KTO (KTO)
  ) u_key_stream (
    .clk_i       (mclk),
    .rst_i       (puc_rst),
    .active_i    (ks_active),
    .clear_i     (ks_clear),
    .kd_word_i   (kd.kd_word),
    .kd_valid_i  (kd.kd_valid),
    .kd_ready_o  (kd.kd_ready),
    .write_key_o (write_key),
    .key_in_o    (key_in),
    .done_o      (ks_done),
    .timeout_o   (ks_timeout)
  );

  assign kd.kd_start = kd_start_c;

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    enable_d   = enable_q;
    update_spm = 1'b0;
    kd_start_c = 1'b0;
    cmd_done   = 1'b0;
    ks_active  = 1'b0;
    ks_clear   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_protect && cmd_unprotect) begin
          state_d  = S_ERR;
          status_d = SPM_ST_COLL;
        end else if (cmd_protect || cmd_unprotect) begin
          state_d  = S_UPDATE;
          status_d = SPM_ST_OK;
          enable_d = cmd_protect;
        end
      end
      S_UPDATE: begin
        update_spm = 1'b1;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        if (ctl_violation) begin
          state_d  = S_ERR;
          status_d = SPM_ST_VIOL;
        end else if (!enable_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_KD_REQ;
        end
      end
      S_KD_REQ: begin
        kd_start_c = 1'b1;
        ks_clear   = 1'b1;
        state_d    = S_KEY;
      end
      S_KEY: begin
        ks_active = 1'b1;
        if (ks_done) begin
          state_d = S_DONE;
        end else if (ks_timeout) begin
          // SPM stays enabled with a partial key.
          state_d  = S_ERR;
          status_d = SPM_ST_TIMEOUT;
        end
      end
      S_DONE: begin
        cmd_done = 1'b1;
        status_d = SPM_ST_OK;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        cmd_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    spm_busy   = (state_q != S_IDLE);
    enable_spm = enable_q && (state_q inside
                 {S_UPDATE, S_CHECK, S_KD_REQ, S_KEY});
    status     = status_q;
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q  <= S_IDLE;
      status_q <= SPM_ST_OK;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      enable_q <= enable_d;
    end
  end

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Directed bench for the SPM command sequencer.
// Cycle 0 is the cycle in which the command pulse is high.
module tb_omsp_spm_cmd_seq;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        cmd_protect;
  logic        cmd_unprotect;
  logic        ctl_violation;
  logic        update_spm;
  logic        enable_spm;
  logic        write_key;
  logic [15:0] key_in;
  logic        spm_busy;
  logic        cmd_done;
  logic [15:0] status;
  logic [6:0]  obs;

  int errors = 0;
  int checks = 0;

  omsp_spm_cmd_seq_if kd ();

  omsp_spm_cmd_seq dut (
    .mclk          (mclk),
    .puc_rst       (puc_rst),
    .cmd_protect   (cmd_protect),
    .cmd_unprotect (cmd_unprotect),
    .ctl_violation (ctl_violation),
    .kd            (kd.slave),
    .update_spm    (update_spm),
    .enable_spm    (enable_spm),
    .write_key     (write_key),
    .key_in        (key_in),
    .spm_busy      (spm_busy),
    .cmd_done      (cmd_done),
    .status        (status)
  );

  always #5 mclk = ~mclk;

  // {busy, update, enable, kd_start, kd_ready, write_key, done}
  assign obs = {spm_busy, update_spm, enable_spm, kd.kd_start,
                kd.kd_ready, write_key, cmd_done};

  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle_in();
    cmd_protect   = 1'b0;
    cmd_unprotect = 1'b0;
    ctl_violation = 1'b0;
    kd.kd_valid   = 1'b0;
    kd.kd_word    = 16'h0000;
  endtask

  function automatic logic [6:0] exp_prot(int c);
    logic [6:0] e;
    e[6] = (c >= 1 && c <= 12);
    e[5] = (c == 1);
    e[4] = (c >= 1 && c <= 11);
    e[3] = (c == 3);
    e[2] = (c >= 4 && c <= 11);
    e[1] = (c >= 4 && c <= 11);
    e[0] = (c == 12);
    return e;
  endfunction

  task automatic test_reset();
    idle_in();
    puc_rst = 1'b0;
    #1 puc_rst = 1'b1;
    kd.kd_valid = 1'b1;
    cyc();
    cyc();
    checks++;
    if (obs !== 7'b0)
      $display("FAIL reset_outputs got=%b want=%b", obs, 7'b0);
    else checks += 0;
    if (obs !== 7'b0) errors++;
    checks++;
    if (key_in !== 16'h0 || status !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got key=%h st=%h want 0/0",
               key_in, status);
    end
    puc_rst = 1'b0;
    idle_in();
    cyc();
  endtask

  task automatic test_protect(input int dup_at);
    logic [15:0] ek;
    cyc();
    cmd_protect = 1'b1;
    kd.kd_valid = 1'b1;
    kd.kd_word  = 16'h1000;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      cmd_protect = (c == dup_at);
      kd.kd_word  = (c >= 4) ? 16'h1000 + 16'(c - 4) : 16'h1000;
      @(negedge mclk);
      checks++;
      if (obs !== exp_prot(c)) begin
        errors++;
        $display("FAIL protect_ctl c=%0d got=%b want=%b",
                 c, obs, exp_prot(c));
      end
      ek = (c >= 4 && c <= 11) ? 16'h1000 + 16'(c - 4) : 16'h0;
      checks++;
      if (key_in !== ek) begin
        errors++;
        $display("FAIL protect_key c=%0d got=%h want=%h",
                 c, key_in, ek);
      end
      if (c == 1 || c == 12) begin
        checks++;
        if (status !== 16'h0000) begin
          errors++;
          $display("FAIL protect_status c=%0d got=%h want=0000",
                   c, status);
        end
      end
    end
    idle_in();
  endtask

  task automatic test_short(input logic prot, input logic viol,
                            input logic [27:0] expv,
                            input logic [15:0] exp_st);
    logic [6:0] e;
    cyc();
    cmd_protect   = prot;
    cmd_unprotect = ~prot;
    kd.kd_valid   = 1'b1;
    kd.kd_word    = 16'hBEEF;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      cmd_protect   = 1'b0;
      cmd_unprotect = 1'b0;
      ctl_violation = viol && (c == 2);
      @(negedge mclk);
      e = expv[27 - 7 * (c - 1) -: 7];
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL short_ctl p=%0b v=%0b c=%0d got=%b want=%b",
                 prot, viol, c, obs, e);
      end
      if (c == 3) begin
        checks++;
        if (status !== exp_st) begin
          errors++;
          $display("FAIL short_status got=%h want=%h",
                   status, exp_st);
        end
      end
    end
    idle_in();
  endtask

  task automatic test_collision();
    cyc();
    cmd_protect   = 1'b1;
    cmd_unprotect = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      cyc();
      cmd_protect   = 1'b0;
      cmd_unprotect = 1'b0;
      @(negedge mclk);
      checks++;
      if (obs !== ((c == 1) ? 7'b1000001 : 7'b0)) begin
        errors++;
        $display("FAIL coll_ctl c=%0d got=%b", c, obs);
      end
      checks++;
      if (status !== 16'h0003) begin
        errors++;
        $display("FAIL coll_status c=%0d got=%h want=0003",
                 c, status);
      end
    end
    idle_in();
  endtask

  task automatic test_timeout(input int gap, input int exp_dc,
                              input logic [15:0] exp_st,
                              input int exp_wr);
    int wr = 0;
    int dc = -1;
    logic [15:0] st = 16'hFFFF;
    cyc();
    cmd_protect = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      cyc();
      cmd_protect = 1'b0;
      kd.kd_valid = (c >= 4 && c <= 6) || (c >= 7 + gap);
      kd.kd_word  = 16'h2000 + 16'(c);
      @(negedge mclk);
      if (write_key === 1'b1) wr++;
      if (cmd_done === 1'b1 && dc < 0) begin
        dc = c;
        st = status;
      end
    end
    checks++;
    if (dc != exp_dc) begin
      errors++;
      $display("FAIL to_done gap=%0d got=%0d want=%0d",
               gap, dc, exp_dc);
    end
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL to_status gap=%0d got=%h want=%h",
               gap, st, exp_st);
    end
    checks++;
    if (wr != exp_wr) begin
      errors++;
      $display("FAIL to_writes gap=%0d got=%0d want=%0d",
               gap, wr, exp_wr);
    end
    idle_in();
  endtask

  task automatic test_reset_mid();
    int wr = 0;
    cyc();
    cmd_protect = 1'b1;
    kd.kd_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      cmd_protect = 1'b0;
      kd.kd_word  = 16'h3000 + 16'(c);
      @(negedge mclk);
      if (write_key === 1'b1) wr++;
    end
    checks++;
    if (wr != 5) begin
      errors++;
      $display("FAIL mid_pre_writes got=%0d want=5", wr);
    end
    cyc();
    puc_rst = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0 || key_in !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset got=%b key=%h want=0/0",
               obs, key_in);
    end
    @(negedge mclk);
    checks++;
    if (obs !== 7'b0 || status !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_hold got=%b st=%h", obs, status);
    end
    cyc();
    puc_rst = 1'b0;
    idle_in();
    test_protect(-1);
  endtask

  initial begin
    test_reset();
    test_protect(-1);
    test_short(1'b1, 1'b1,
               {7'b1110000, 7'b1010000, 7'b1000001, 7'b0},
               16'h0001);
    test_short(1'b0, 1'b0,
               {7'b1100000, 7'b1000000, 7'b1000001, 7'b0},
               16'h0000);
    test_collision();
    test_protect(6);
    test_timeout(255, 262, 16'h0002, 3);
    test_timeout(254, 266, 16'h0000, 8);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
